// File: rtl/fact_mmio_ctrl.sv
// MMIO sequencer for the factorial accelerator: 4-word register window, start pulse, done/timeout wait.
// Optional FACT_IRQ_EN: registered completion interrupt irq = IE & done; otherwise irq is tied low.
module fact_mmio_ctrl #(
    parameter int unsigned MAX_N   = 12,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic [3:0]  fact_n,
    output logic        fact_start,
    input  logic        fact_done,
    input  logic [31:0] fact_result,
    output logic        irq
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]       r_state;
    logic [3:0]       r_n;
    logic [31:0]      r_result;
    logic             r_ie;
    logic             r_done;
    logic             r_err;
    logic             r_timeout;
    logic [CNT_W-1:0] r_cnt;

    logic w_wr;
    logic w_wr_ctrl;
    logic w_wr_n;
    logic w_go;
    logic w_clr;
    logic w_busy;
    logic w_n_ok;
    logic w_expire;
    logic w_unused;

    assign w_wr      = sel & we;
    assign w_wr_ctrl = w_wr & (addr == 2'd0);
    assign w_wr_n    = w_wr & (addr == 2'd1);
    assign w_go      = w_wr_ctrl & wd[0];
    assign w_clr     = w_wr_ctrl & wd[1];
    assign w_busy    = (r_state != S_IDLE);
    assign w_n_ok    = ({28'd0, r_n} <= MAX_N);
    assign w_expire  = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_unused  = ^wd[31:4];

    assign fact_n     = r_n;
    assign fact_start = (r_state == S_START);

    // CLR is applied ahead of GO/err updates below, so later assignments win.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_n       <= '0;
            r_result  <= '0;
            r_ie      <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_ie <= wd[2];
            end
            if (w_wr_n && !w_busy) begin
                r_n <= wd[3:0];
            end
            if (w_clr) begin
                r_err     <= 1'b0;
                r_timeout <= 1'b0;
                if (!w_busy) begin
                    r_done <= 1'b0;
                end
            end
            if (w_busy && (w_go || w_wr_n)) begin
                r_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        if (w_n_ok) begin
                            r_state   <= S_START;
                            r_done    <= 1'b0;
                            r_err     <= 1'b0;
                            r_timeout <= 1'b0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    // done takes priority over an expiring counter in the same cycle
                    if (fact_done) begin
                        r_result <= fact_result;
                        r_done   <= 1'b1;
                        r_state  <= S_IDLE;
                    end else if (w_expire) begin
                        r_err     <= 1'b1;
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        rd = 32'd0;
        if (sel) begin
            case (addr)
                2'd0:    rd = {29'd0, r_ie, 2'b00};
                2'd1:    rd = {28'd0, r_n};
                2'd2:    rd = {28'd0, r_timeout, r_err, r_done, w_busy};
                default: rd = r_result;
            endcase
        end
    end

`ifdef FACT_IRQ_EN
    logic r_irq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_ie & r_done;
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_fact_mmio_ctrl.sv
// Bench for fact_mmio_ctrl: directed plus randomized runs against a register-level model and a
// behavioural accelerator that answers each start pulse after a chosen delay.
module tb_fact_mmio_ctrl;

    localparam int MAX_N   = 12;
    localparam int TIMEOUT = 1024;
`ifdef FACT_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [3:0]  fact_n;
    logic        fact_start;
    logic        fact_done;
    logic [31:0] fact_result;
    logic        irq;

    always #5 clk = ~clk;

    fact_mmio_ctrl #(.MAX_N(MAX_N), .TIMEOUT(TIMEOUT), .CNT_W(11)) dut (
        .clk(clk), .reset(reset), .sel(sel), .we(we), .addr(addr), .wd(wd), .rd(rd),
        .fact_n(fact_n), .fact_start(fact_start), .fact_done(fact_done),
        .fact_result(fact_result), .irq(irq)
    );

    int n_total = 0;
    int n_pass  = 0;

    int       acc_delay = 0;
    bit       acc_hold  = 1'b0;
    int       start_cnt = 0;
    int       cd        = 0;
    bit       pending   = 1'b0;
    logic [3:0] acc_n   = '0;

    logic [31:0] m_result;
    bit m_ie, m_done, m_err, m_to;

    function automatic logic [31:0] fact(input int k);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 2; i <= k; i++) p = p * 32'(i);
        return p;
    endfunction

    function automatic logic [31:0] m_status();
        return {28'd0, m_to, m_err, m_done, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Accelerator: raises done acc_delay cycles into WAIT (never if negative); pulse unless acc_hold.
    initial begin
        fact_done   = 1'b0;
        fact_result = 32'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pending   = 1'b0;
                fact_done = 1'b0;
            end else begin
                if (pending) begin
                    if (cd == 0) begin
                        fact_done   = 1'b1;
                        fact_result = fact(int'(acc_n));
                        pending     = 1'b0;
                    end else begin
                        fact_done   = 1'b0;
                        fact_result = $urandom;
                        cd--;
                    end
                end else if (fact_done && !acc_hold) begin
                    fact_done   = 1'b0;
                    fact_result = $urandom;
                end
                if (fact_start) begin
                    start_cnt++;
                    acc_n   = fact_n;
                    pending = 1'b1;
                    cd      = (acc_delay < 0) ? 32'h3fff_ffff : acc_delay;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wd = d;
        @(posedge clk);
        #1;
        sel = 1'b0; we = 1'b0; wd = 32'd0;
        if (a == 2'd0) m_ie = d[2];
    endtask

    task automatic rdreg(input logic [1:0] a, output logic [31:0] v);
        sel = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        v = rd;
        @(posedge clk);
        #1;
        sel = 1'b0;
    endtask

    task automatic wait_idle(output int busy_cycles, output logic irq_at);
        busy_cycles = 0;
        sel = 1'b1; we = 1'b0; addr = 2'd2;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (rd[0] !== 1'b1) break;
            busy_cycles++;
        end
        irq_at = irq;
        @(posedge clk);
        #1;
        sel = 1'b0;
        check("wait_bound", 32'(busy_cycles < 4000), 32'd1);
    endtask

    // Writes N then CTRL, updating the model by the register-map rules.
    task automatic launch(input int n, input int d, input logic [2:0] ctrl);
        acc_delay = d;
        wr(2'd1, 32'(n));
        wr(2'd0, {29'd0, ctrl});
        if (ctrl[1]) begin m_done = 0; m_err = 0; m_to = 0; end
        if (ctrl[0]) begin
            if (n <= MAX_N) begin m_done = 0; m_err = 0; m_to = 0; end
            else m_err = 1;
        end
    endtask

    initial begin
        logic [31:0] v;
        int cyc;
        logic irq_at;
        int s0;
        int n;
        int d;
        bit ie;

        reset = 1'b1; sel = 1'b0; we = 1'b0; addr = 2'd0; wd = 32'd0;
        m_result = 0; m_ie = 0; m_done = 0; m_err = 0; m_to = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_start", fact_start, 0);
        check("rst_irq", irq, 0);
        sel = 1'b1; addr = 2'd2;
        #1 check("rst_status_live", rd, 0);
        sel = 1'b0;
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rdreg(2'(a), v);
            check($sformatf("rst_rd%0d", a), v, 0);
        end

        // N=5, done four cycles into WAIT
        s0 = start_cnt;
        launch(5, 3, 3'b001);
        check("go_start_pulse", fact_start, 1);
        check("go_fact_n", fact_n, 5);
        step();
        check("start_width", fact_start, 0);
        wait_idle(cyc, irq_at);
        m_done = 1; m_result = fact(5);
        check("n5_wait_cycles", cyc, 4);
        check("n5_start_count", start_cnt - s0, 1);
        rdreg(2'd2, v); check("n5_status", v, m_status());
        rdreg(2'd3, v); check("n5_result", v, 120);
        sel = 1'b0; addr = 2'd3;
        #1 check("nosel_rd", rd, 0);

        // illegal operand
        wr(2'd0, 32'd2);
        m_done = 0; m_err = 0; m_to = 0;
        s0 = start_cnt;
        launch(13, 0, 3'b001);
        check("badn_no_start", fact_start, 0);
        rdreg(2'd1, v); check("badn_readback", v, 13);
        check("badn_start_count", start_cnt - s0, 0);
        rdreg(2'd2, v); check("badn_status", v, 32'h4);
        wr(2'd0, 32'd2);
        m_err = 0;
        rdreg(2'd2, v); check("clr_status", v, 32'h0);

        // timeout: done never arrives
        launch(3, -1, 3'b001);
        wait_idle(cyc, irq_at);
        m_err = 1; m_to = 1;
        check("to_busy_cycles", cyc, TIMEOUT + 1);
        rdreg(2'd2, v); check("to_status", v, 32'hC);
        rdreg(2'd3, v); check("to_result_kept", v, m_result);

        // done on the very cycle the counter expires
        launch(9, TIMEOUT - 1, 3'b001);
        wait_idle(cyc, irq_at);
        m_done = 1; m_result = fact(9);
        check("edge_busy_cycles", cyc, TIMEOUT + 1);
        rdreg(2'd2, v); check("edge_status", v, m_status());
        rdreg(2'd3, v); check("edge_result", v, 362880);

        // writes while busy
        n = $urandom_range(0, MAX_N);
        s0 = start_cnt;
        launch(n, 20, 3'b001);
        step();
        wr(2'd0, 32'd1);
        wr(2'd1, 32'd7);
        check("busy_fact_n", fact_n, 32'(n));
        rdreg(2'd2, v); check("busy_err_status", v, 32'h5);
        wr(2'd0, 32'd2);
        rdreg(2'd2, v); check("busy_clr_status", v, 32'h1);
        wr(2'd0, 32'd1);
        wait_idle(cyc, irq_at);
        m_err = 1; m_done = 1; m_result = fact(n);
        check("busy_start_count", start_cnt - s0, 1);
        rdreg(2'd2, v); check("busy_final_status", v, 32'h6);
        rdreg(2'd3, v); check("busy_result", v, m_result);

        // done held high from a previous run must wait for WAIT
        acc_hold = 1'b1;
        launch(6, 0, 3'b001);
        wait_idle(cyc, irq_at);
        m_done = 1; m_result = fact(6);
        rdreg(2'd3, v); check("hold_first_result", v, 720);
        launch(2, 2, 3'b001);
        wait_idle(cyc, irq_at);
        m_done = 1; m_result = fact(2);
        check("hold_busy_cycles", cyc, 4);
        rdreg(2'd3, v); check("hold_second_result", v, 2);
        acc_hold = 1'b0;
        step();

        // interrupt
        launch(4, 1, 3'b101);
        wait_idle(cyc, irq_at);
        m_done = 1; m_result = fact(4);
        check("irq_at_done", irq_at, 0);
        @(negedge clk);
        check("irq_after_done", irq, IRQ_ON);
        step();
        rdreg(2'd3, v); check("irq_result", v, 24);
        rdreg(2'd0, v); check("ctrl_readback", v, 32'h4);
        wr(2'd0, 32'd6);
        m_done = 0;
        check("irq_clr_edge", irq, IRQ_ON);
        step();
        check("irq_after_clr", irq, 0);

        // randomized runs with CLR+GO issued together
        for (int it = 0; it < 12; it++) begin
            n  = $urandom_range(0, 15);
            d  = $urandom_range(0, 8);
            ie = 1'($urandom_range(0, 1));
            s0 = start_cnt;
            launch(n, d, {ie, 2'b11});
            if (n <= MAX_N) begin
                wait_idle(cyc, irq_at);
                m_done = 1; m_result = fact(n);
                check($sformatf("rnd%0d_cycles", it), cyc, d + 2);
                @(negedge clk);
                check($sformatf("rnd%0d_irq", it), irq, IRQ_ON & ie);
                step();
            end else begin
                check($sformatf("rnd%0d_no_start", it), fact_start, 0);
                step();
                check($sformatf("rnd%0d_start_count", it), start_cnt - s0, 0);
            end
            rdreg(2'd2, v); check($sformatf("rnd%0d_status", it), v, m_status());
            rdreg(2'd3, v); check($sformatf("rnd%0d_result", it), v, m_result);
        end

        // asynchronous reset in the START cycle
        launch(5, -1, 3'b001);
        check("ar_start_before", fact_start, 1);
        #2 reset = 1'b1;
        #1 check("ar_start_async", fact_start, 0);
        sel = 1'b1; addr = 2'd2;
        #1 check("ar_status", rd, 0);
        sel = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        m_result = 0; m_ie = 0; m_done = 0; m_err = 0; m_to = 0;
        rdreg(2'd1, v); check("ar_n", v, 0);
        rdreg(2'd3, v); check("ar_result", v, m_result);
        check("ar_irq", irq, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fact_mmio_ctrl.md
Name: fact_mmio_ctrl

Overview:
Memory-mapped controller that sequences the factorial accelerator on behalf of the pipelined MIPS core. It decodes MEM-stage stores and loads to a 4-word register window and validates the operand. It drives the single-cycle start pulse, waits for done with a timeout, and latches the result and status for the CPU to poll.

Parameters:
MAX_N, 12, largest legal operand; 13! overflows 32 bits.
TIMEOUT, 1024, cycles allowed in WAIT before an error is flagged; must be >= 2.
CNT_W, 11, timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
sel  in  1  window select from the SoC address decoder; qualifies both we and reads.
we  in  1  store strobe (memwrite of the MEM stage).
addr  in  2  word offset, i.e. aluout[3:2].
wd  in  32  store data.
rd  out  32  load data, combinational from addr (same-cycle readdata).
fact_n  out  4  operand to the accelerator.
fact_start  out  1  one-cycle start pulse.
fact_done  in  1  accelerator completion; level or pulse.
fact_result  in  32  accelerator result, valid while fact_done=1.
irq  out  1  completion interrupt (see Optional Feature).

Behaviour:
- Register map (offset, access):
  - 0 CTRL (W): bit0 GO, bit1 CLR (clears done and err), bit2 IE. Reads return {29'b0, IE, 2'b0}.
  - 1 N (R/W): bits[3:0] hold the operand; upper bits read 0.
  - 2 STATUS (R): bit0 busy, bit1 done, bit2 err, bit3 timeout; other bits 0.
  - 3 RESULT (R): latched result.
- rd returns 0 when sel=0. Writes take effect only when sel=1 and we=1.
- Reset: FSM=IDLE; N, RESULT, IE, done, err, timeout, counter all 0; fact_start=0; irq=0; rd=0.
- FSM states: IDLE, START, WAIT.
  - IDLE:
    - GO with N<=MAX_N -> START; clear done, err and timeout.
    - GO with N>MAX_N -> stay in IDLE, set err, do not pulse start.
  - START: fact_start=1 for exactly this cycle; counter cleared -> WAIT.
  - WAIT: counter increments every cycle.
    - fact_done=1 -> latch RESULT<=fact_result, set done -> IDLE.
    - Counter reaches TIMEOUT-1 with no done -> set err and timeout -> IDLE; RESULT unchanged.
- busy = (state != IDLE).
- fact_n is driven from N continuously. A write to N while busy is ignored and sets err.
- GO while busy: ignored, sets err, running operation continues.
- Same-cycle done and timeout expiry: done wins; no error.
- CLR and GO written together in IDLE: CLR applied first, then GO evaluated.
- CLR while busy: clears err and timeout only; the operation continues.
- fact_done in IDLE or START is ignored. A held-high done from a previous run must not complete a new run before WAIT is reached.
- Latency from GO store to fact_start: 1 cycle. Minimum GO-to-done-visible: 3 cycles.
- Asynchronous reset mid-operation returns to IDLE immediately and clears all state. fact_start deasserts asynchronously.

Optional Feature:
FACT_IRQ_EN
- Defined: irq is registered, irq = IE & done. It rises the cycle after done sets and drops when done is cleared by CLR or a new GO.
- Undefined: irq tied to 0. The IE bit is still writable and readable, so software sees an identical register map.

Test Plan:
- Reset, then read all four offsets -> rd=0 for each. fact_start=0, busy=0.
- Write N=5, write CTRL=1, model done after 4 cycles with result 120 -> one-cycle start pulse one cycle after GO, fact_n=5. STATUS then reads 0x2 and RESULT reads 120.
- Write N=13, then GO -> no start pulse, STATUS=0x4. Write CTRL=2 (CLR) -> STATUS=0x0.
- GO with N=3 and the model never raising done -> busy for exactly TIMEOUT cycles in WAIT, then STATUS=0xC; RESULT keeps its previous value.
- During WAIT, write GO and write N=7 -> err set, no second start, fact_n unchanged. Completion still latches the result, STATUS=0x6.
- Build with FACT_IRQ_EN: set IE, run N=4 -> irq high the cycle after done sets, RESULT=24. CLR -> irq low next cycle. Same stimulus without the macro -> irq stays 0 throughout.
